inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction-fetch front end for the single-issue MIPS core.
- Drives the instruction-memory request/acknowledge interface, keeps the PC, and hands the fetched word to the ID stage over a valid/ready handshake. ID feeds the word's opcode field [31:26] to the main control decoder.
- Accepts one PC redirect per cycle from the branch/jump resolution logic.
- Allows at most one memory request in flight. Drops responses that belong to a redirected fetch.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset; bits [1:0] must be 0.
- IMEM_AW, 32, width of the instruction address and PC.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; high exactly while the FSM is in FETCH.
- imem_addr  output  IMEM_AW  word-aligned fetch address; equals pc when imem_req=1.
- imem_ack  input  1  one-cycle pulse: imem_rdata is valid; arrives 1 or more cycles after imem_req.
- imem_rdata  input  32  returned instruction word.
- redirect  input  1  load redirect_pc as the next fetch PC; discard any held or in-flight instruction.
- redirect_pc  input  IMEM_AW  redirect target; bits [1:0] are ignored (forced 0).
- inst_valid  output  1  inst/inst_pc hold a valid instruction for ID.
- inst  output  32  fetched instruction.
- inst_pc  output  IMEM_AW  address of inst.
- id_ready  input  1  ID accepts inst this cycle when inst_valid=1.
- fetch_cnt  output  32  count of handed-off instructions (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=FETCH, drop=0.
  - inst_valid=0, inst=0, inst_pc=0, fetch_cnt=0.
  - rst overrides every other input, including a mid-request state; a late imem_ack after reset is ignored.
- State machine:
  - FETCH: imem_req=1, imem_addr=pc. Next state is always WAIT. A request counts as issued after one cycle.
  - WAIT: imem_req=0.
    - imem_ack=1 and drop=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, next state HOLD.
    - imem_ack=1 and drop=1: discard the data, drop<=0, next state FETCH.
    - imem_ack=0: stay in WAIT.
  - HOLD: inst_valid=1, and inst/inst_pc stay stable. If id_ready=1, then inst_valid<=0 and the next state is FETCH; otherwise stay.
- Handshake: a transfer occurs when inst_valid & id_ready & !redirect. Best-case throughput is one instruction per 3 cycles with a 1-cycle memory.
- Redirect (has priority over everything except rst):
  - pc<=redirect_pc with bits [1:0] cleared, and inst_valid<=0.
  - In FETCH: the request just issued is outstanding, so next state is WAIT with drop<=1.
  - In WAIT with imem_ack=0: drop<=1, stay in WAIT.
  - In WAIT with imem_ack=1: discard the data, drop<=0, next state FETCH.
  - In HOLD: the held instruction is discarded even if id_ready=1 (no transfer is counted), next state FETCH.
- PC arithmetic: pc+4 is modulo 2^IMEM_AW, so 32'hFFFF_FFFC wraps to 0.
- imem_ack outside WAIT is ignored.
- All outputs are registered except imem_req and imem_addr, which decode directly from state and pc.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: fetch_cnt increments by 1 on each transfer and wraps modulo 2^32. Reset clears it to 0.
- Not defined: fetch_cnt is tied to 32'd0 and no counter flop is built. The port remains present so the interface is identical.

Test Plan:
- Reset check: rst=1 for 2 cycles, then 0 -> first cycle after reset has imem_req=1, imem_addr=BFC00000, inst_valid=0, fetch_cnt=0.
- Normal fetch: ack 1 cycle after request with rdata=8C080004, id_ready=1 -> inst=8C080004 and inst_pc=BFC00000 for one cycle. Next imem_addr=BFC00004. fetch_cnt=1 with the macro, 0 without.
- Backpressure: id_ready=0 for 5 cycles while in HOLD -> inst_valid stays 1, inst stays stable, imem_req stays 0. Raising id_ready gives one transfer, then a request for the next address.
- Redirect in WAIT: redirect=1, redirect_pc=BFC00100; ack arrives 2 cycles later with 12345678 -> 12345678 never appears with inst_valid=1, and the next request has imem_addr=BFC00100.
- Redirect and id_ready together in HOLD, redirect_pc=BFC00103 -> no transfer, fetch_cnt unchanged, next imem_addr=BFC00100.
- Wrap and reset mid-request: redirect to FFFFFFFC, fetch it, and the next address is 00000000. Assert rst while in WAIT, then send an ack -> ack is ignored, and the first request after reset has imem_addr=BFC00000.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, single outstanding imem request, ID handoff.
// Optional handoff counter on fetch_cnt when FETCH_PERF_CNT_EN is defined.
module inst_fetch_unit #(
  parameter int unsigned         IMEM_AW  = 32,
  parameter logic [IMEM_AW-1:0]  RESET_PC = 32'hBFC0_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [IMEM_AW-1:0] redirect_pc,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [IMEM_AW-1:0] inst_pc,
  input  logic               id_ready,
  output logic [31:0]        fetch_cnt
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             state, state_n;
  logic [IMEM_AW-1:0] pc, pc_n;
  logic               drop, drop_n;
  logic               valid_n;
  logic [31:0]        inst_n;
  logic [IMEM_AW-1:0] ipc_n;

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drop       <= drop_n;
      inst_valid <= valid_n;
      inst       <= inst_n;
      inst_pc    <= ipc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    valid_n = inst_valid;
    inst_n  = inst;
    ipc_n   = inst_pc;
    unique case (state)
      S_FETCH: begin
        state_n = S_WAIT;
        if (redirect) drop_n = 1'b1;
      end
      S_WAIT: begin
        if (imem_ack) begin
          drop_n = 1'b0;
          if (drop || redirect) begin
            state_n = S_FETCH;
          end else begin
            inst_n  = imem_rdata;
            ipc_n   = pc;
            valid_n = 1'b1;
            pc_n    = pc + IMEM_AW'(4);
            state_n = S_HOLD;
          end
        end else if (redirect) begin
          drop_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || id_ready) begin
          valid_n = 1'b0;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_FETCH;
    endcase
    // redirect wins over any sequential pc update or held instruction
    if (redirect) begin
      pc_n    = {redirect_pc[IMEM_AW-1:2], 2'b00};
      valid_n = 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        xfer;
  logic [31:0] cnt;

  assign xfer      = inst_valid & id_ready & ~redirect;
  assign fetch_cnt = cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (xfer) cnt <= cnt + 32'd1;
  end
`else
  assign fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed table, corner sequences,
// random traffic against a transaction-level reference.
module tb_inst_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        id_ready = 1'b0;
  logic [31:0] fetch_cnt;

  int ntests = 0;
  int nfail  = 0;

  inst_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .id_ready   (id_ready),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] expcnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C1D_0000;
  endfunction

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] ipc;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic rd,
                              logic c, logic q, logic [31:0] ad, logic v,
                              logic [31:0] in, logic [31:0] ip, int n);
    vec_t t;
    t.rst = r; t.ack = a; t.rdata = d; t.ready = rd;
    t.chk = c; t.req = q; t.addr = ad; t.valid = v;
    t.inst = in; t.ipc = ip; t.cnt = n;
    return t;
  endfunction

  vec_t vt[14];

  // random-phase reference state
  logic [31:0] next_pc;
  int          xfers;
  bit          pend;
  int          pcnt;
  logic [31:0] paddr;
  logic [31:0] r;

  initial begin
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 1, 1, 1, RST_PC, 0, 0, 0, 0);
    vt[3]  = mk(0, 1, 32'h8C08_0004, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h8C08_0004, RST_PC, 0);
    vt[5]  = mk(0, 0, 0, 0, 1, 1, 32'hBFC0_0004, 0, 0, 0, 1);
    vt[6]  = mk(0, 1, 32'h0085_1020, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 7; i <= 11; i++)
      vt[i] = mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h0085_1020, 32'hBFC0_0004, 1);
    vt[12] = mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h0085_1020, 32'hBFC0_0004, 1);
    vt[13] = mk(0, 0, 0, 1, 1, 1, 32'hBFC0_0008, 0, 0, 0, 2);

    for (int i = 0; i < 14; i++) begin
      step();
      if (vt[i].chk) begin
        chk($sformatf("v%0d req", i), 32'(imem_req), 32'(vt[i].req));
        if (vt[i].req)
          chk($sformatf("v%0d addr", i), imem_addr, vt[i].addr);
        chk($sformatf("v%0d valid", i), 32'(inst_valid), 32'(vt[i].valid));
        if (vt[i].valid) begin
          chk($sformatf("v%0d inst", i), inst, vt[i].inst);
          chk($sformatf("v%0d ipc", i), inst_pc, vt[i].ipc);
        end
        chk($sformatf("v%0d cnt", i), fetch_cnt, expcnt(vt[i].cnt));
      end
      rst        = vt[i].rst;
      imem_ack   = vt[i].ack;
      imem_rdata = vt[i].rdata;
      id_ready   = vt[i].ready;
    end

    // redirect while waiting; the stale ack must be dropped
    step();
    chk("rw req", 32'(imem_req), 0);
    redirect = 1; redirect_pc = 32'hBFC0_0100;
    step();
    chk("rw v1", 32'(inst_valid), 0);
    redirect = 0;
    step();
    chk("rw v2", 32'(inst_valid), 0);
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 0;
    chk("rw stale", 32'(inst_valid), 0);
    chk("rw req2", 32'(imem_req), 1);
    chk("rw addr", imem_addr, 32'hBFC0_0100);
    step();
    imem_ack = 1; imem_rdata = 32'hAAAA_0001;
    step();
    imem_ack = 0;
    chk("rh valid", 32'(inst_valid), 1);
    chk("rh inst", inst, 32'hAAAA_0001);
    chk("rh ipc", inst_pc, 32'hBFC0_0100);
    chk("rh cnt0", fetch_cnt, expcnt(2));
    // redirect together with id_ready in HOLD
    redirect = 1; redirect_pc = 32'hBFC0_0103; id_ready = 1;
    step();
    redirect = 0;
    chk("rh valid2", 32'(inst_valid), 0);
    chk("rh req", 32'(imem_req), 1);
    chk("rh addr", imem_addr, 32'hBFC0_0100);
    chk("rh cnt1", fetch_cnt, expcnt(2));
    // redirect in FETCH to the top word, then wrap
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    imem_ack = 1; imem_rdata = 32'hDEAD_0000;
    step();
    imem_ack = 0;
    chk("wr req", 32'(imem_req), 1);
    chk("wr addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr valid", 32'(inst_valid), 0);
    step();
    imem_ack = 1; imem_rdata = 32'h0BAD_0F0F;
    step();
    imem_ack = 0;
    chk("wr inst", inst, 32'h0BAD_0F0F);
    chk("wr ipc", inst_pc, 32'hFFFF_FFFC);
    chk("wr v", 32'(inst_valid), 1);
    id_ready = 1;
    step();
    chk("wr wrap", imem_addr, 32'h0000_0000);
    chk("wr req2", 32'(imem_req), 1);
    chk("wr cnt", fetch_cnt, expcnt(3));
    // reset in WAIT, late acks afterwards
    step();
    chk("rs req", 32'(imem_req), 0);
    rst = 1; imem_ack = 1; imem_rdata = 32'hCAFE_BABE;
    step();
    chk("rs req2", 32'(imem_req), 1);
    chk("rs addr", imem_addr, RST_PC);
    chk("rs valid", 32'(inst_valid), 0);
    chk("rs cnt", fetch_cnt, 32'd0);
    rst = 0;
    step();
    chk("rs ign1", 32'(inst_valid), 0);
    chk("rs req3", 32'(imem_req), 0);
    imem_ack = 0;
    step();
    chk("rs ign2", 32'(inst_valid), 0);
    imem_ack = 1; imem_rdata = 32'h1111_2222;
    step();
    imem_ack = 0;
    chk("rs inst", inst, 32'h1111_2222);
    chk("rs ipc", inst_pc, RST_PC);

    // random traffic
    rst = 1; redirect = 0; id_ready = 0;
    step();
    step();
    rst = 0;
    next_pc = RST_PC; xfers = 0; pend = 0; pcnt = 0; paddr = '0;
    for (int i = 0; i < 3000; i++) begin
      if (imem_req) begin
        chk("rnd addr", imem_addr, next_pc);
        chk("rnd one", 32'(pend), 0);
      end
      if (inst_valid) begin
        chk("rnd ipc", inst_pc, next_pc);
        chk("rnd inst", inst, memf(next_pc));
        chk("rnd hreq", 32'(imem_req), 0);
      end
      chk("rnd cnt", fetch_cnt, expcnt(xfers));
      imem_ack = 0;
      imem_rdata = $urandom();
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          imem_ack = 1; imem_rdata = memf(paddr); pend = 0;
        end
      end
      if (imem_req) begin
        pend = 1; paddr = imem_addr; pcnt = $urandom_range(1, 3);
      end
      r = $urandom();
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = (r[31:30] == 2'b00) ? (32'hFFFF_FFF0 | (r & 32'hF))
                                        : {16'hBFC0, r[15:0]};
      id_ready = $urandom_range(0, 1) == 1;
      if (redirect) begin
        next_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (inst_valid && id_ready) begin
        next_pc = next_pc + 32'd4;
        xfers++;
      end
      step();
    end
    ntests++;
    if (xfers < 100) begin
      nfail++;
      $display("FAIL rnd progress: got %0d transfers expected >= 100", xfers);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
